// File: rtl/rgmii_rx_deframer_pkg.sv
// Shared types and constants for the RGMII receive deframer.
package rgmii_rx_deframer_pkg;

  // Receive FSM states.
  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    PREAMBLE  = 3'd2,
    PAYLOAD   = 3'd3,
    DROP      = 3'd4
  } state_e;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  localparam int DEF_MIN_FRAME = 64;
  localparam int DEF_MAX_FRAME = 1518;

endpackage

// File: rtl/rgmii_rx_deframer_iddr.sv
// Generic input DDR: captures on both clock edges and presents the
// rising/falling pair of one bit time together after the next rising edge.
module iddr #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] d2
);

  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] d1_q;
  logic [WIDTH-1:0] d2_q;

  // Rising-edge capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rise_q <= '0;
    else        rise_q <= d;
  end

  // Falling-edge capture, half a cycle after the matching rising sample.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) fall_q <= '0;
    else        fall_q <= d;
  end

  // Re-time the pair into the rising-edge domain so both halves line up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1_q <= '0;
      d2_q <= '0;
    end else begin
      d1_q <= rise_q;
      d2_q <= fall_q;
    end
  end

  assign d1 = d1_q;
  assign d2 = d2_q;

endmodule

// File: rtl/rgmii_rx_deframer.sv
// RGMII receive deframer: DDR capture, preamble/SFD strip, length and
// error qualification, AXI-Stream style output with good/bad frame counters.
module rgmii_rx_deframer
  import rgmii_rx_deframer_pkg::*;
#(
  parameter int MIN_FRAME = DEF_MIN_FRAME,
  parameter int MAX_FRAME = DEF_MAX_FRAME,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           rgmii_rxd,
  input  logic                 rgmii_rx_ctl,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  output logic [CNT_WIDTH-1:0] frames_good,
  output logic [CNT_WIDTH-1:0] frames_bad
);

  // Length counter must hold MAX_FRAME+1 and is never narrower than 11 bits.
  localparam int LEN_W = ($clog2(MAX_FRAME + 2) > 11) ? $clog2(MAX_FRAME + 2) : 11;
  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_FRAME);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_FRAME);
  localparam logic [LEN_W-1:0] SAT_L = LEN_W'(MAX_FRAME + 1);

  // DDR capture of {ctl, rxd}
  logic [4:0] ddr_rise;
  logic [4:0] ddr_fall;

  iddr #(.WIDTH(5)) u_iddr (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({rgmii_rx_ctl, rgmii_rxd}),
    .d1    (ddr_rise),
    .d2    (ddr_fall)
  );

  logic [7:0] rx_byte;
  logic       dv;
  logic       er;

  assign rx_byte = {ddr_fall[3:0], ddr_rise[3:0]};
  assign dv      = ddr_rise[4];
  assign er      = ddr_rise[4] ^ ddr_fall[4];

  // Frame state
  state_e           state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic             have_q, have_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             err_q, err_d;

  // Output and counter registers
  logic [7:0]           tdata_q;
  logic                 tvalid_q;
  logic                 tlast_q;
  logic                 tuser_q;
  logic [CNT_WIDTH-1:0] good_q;
  logic [CNT_WIDTH-1:0] bad_q;

  // Per-cycle decisions from the FSM
  logic             emit;
  logic             emit_last;
  logic             emit_user;
  logic             cnt_good;
  logic             cnt_bad;
  logic [LEN_W-1:0] len_inc;

  // Next-state logic: frame delineation, one-byte hold, length/error tracking.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    have_d    = have_q;
    len_d     = len_q;
    err_d     = err_q;
    emit      = 1'b0;
    emit_last = 1'b0;
    emit_user = 1'b0;
    cnt_good  = 1'b0;
    cnt_bad   = 1'b0;
    len_inc   = (len_q == SAT_L) ? len_q : len_q + 1'b1;

    // dv=0 cycles carry in-band status when er=1; every branch below keys
    // on dv only, so that status never affects the FSM.
    case (state_q)
      WAIT_IDLE: begin
        if (!dv) state_d = IDLE;
      end

      IDLE: begin
        if (dv) state_d = (rx_byte == PREAMBLE_BYTE) ? PREAMBLE : DROP;
      end

      PREAMBLE: begin
        if (!dv) begin
          state_d = IDLE;
        end else if (er) begin
          state_d = DROP;
        end else if (rx_byte == SFD_BYTE) begin
          state_d = PAYLOAD;
          have_d  = 1'b0;
          len_d   = '0;
          err_d   = 1'b0;
        end else if (rx_byte != PREAMBLE_BYTE) begin
          state_d = DROP;
        end
      end

      PAYLOAD: begin
        if (!dv) begin
          // End of frame: flush the held byte as the last beat.
          state_d = IDLE;
          have_d  = 1'b0;
          if (have_q) begin
            emit      = 1'b1;
            emit_last = 1'b1;
            emit_user = err_q || (len_q < MIN_L) || (len_q > MAX_L);
            cnt_good  = !emit_user;
            cnt_bad   = emit_user;
          end else begin
            // SFD directly followed by end of carrier: empty frame.
            cnt_bad = 1'b1;
          end
        end else if (len_q >= MAX_L) begin
          // Held byte is byte MAX_FRAME and another arrives: truncate.
          emit      = have_q;
          emit_last = 1'b1;
          emit_user = 1'b1;
          cnt_bad   = 1'b1;
          have_d    = 1'b0;
          state_d   = DROP;
        end else begin
          emit   = have_q;
          hold_d = rx_byte;
          have_d = 1'b1;
          len_d  = len_inc;
          err_d  = err_q | er;
        end
      end

      DROP: begin
        if (!dv) state_d = IDLE;
      end

      default: state_d = WAIT_IDLE;
    endcase
  end

  // FSM and frame-tracking registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_IDLE;
      hold_q  <= '0;
      have_q  <= 1'b0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      have_q  <= have_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

  // Output beat register; tdata is zeroed when no beat is presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
    end else begin
      tdata_q  <= emit ? hold_q : 8'h00;
      tvalid_q <= emit;
      tlast_q  <= emit & emit_last;
      tuser_q  <= emit & emit_last & emit_user;
    end
  end

  // Saturating frame counters, updated together with the tlast beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_q <= '0;
      bad_q  <= '0;
    end else begin
      if (cnt_good && (good_q != {CNT_WIDTH{1'b1}})) good_q <= good_q + 1'b1;
      if (cnt_bad  && (bad_q  != {CNT_WIDTH{1'b1}})) bad_q  <= bad_q + 1'b1;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign frames_good   = good_q;
  assign frames_bad    = bad_q;

endmodule

// File: tb/tb_rgmii_rx_deframer.sv
// Directed bench for rgmii_rx_deframer. A second instance with 2-bit
// counters shares the stimulus to exercise counter saturation quickly.
module tb_rgmii_rx_deframer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  rxd;
  logic        ctl;
  logic [7:0]  tdata;
  logic        tvalid, tlast, tuser;
  logic [15:0] good, bad;
  logic [7:0]  tdata_s;
  logic        tvalid_s, tlast_s, tuser_s;
  logic [1:0]  good_s, bad_s;

  int n_checks = 0;
  int n_errors = 0;

  logic [9:0] beats[$];

  always #5 clk = ~clk;

  rgmii_rx_deframer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rgmii_rxd     (rxd),
    .rgmii_rx_ctl  (ctl),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tlast  (tlast),
    .m_axis_tuser  (tuser),
    .frames_good   (good),
    .frames_bad    (bad)
  );

  rgmii_rx_deframer #(.CNT_WIDTH(2)) dut_s (
    .clk           (clk),
    .rst_n         (rst_n),
    .rgmii_rxd     (rxd),
    .rgmii_rx_ctl  (ctl),
    .m_axis_tdata  (tdata_s),
    .m_axis_tvalid (tvalid_s),
    .m_axis_tlast  (tlast_s),
    .m_axis_tuser  (tuser_s),
    .frames_good   (good_s),
    .frames_bad    (bad_s)
  );

  // Collect beats away from the active edge as {tuser, tlast, tdata}.
  always @(negedge clk) begin
    if (tvalid) beats.push_back({tuser, tlast, tdata});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One RGMII bit time: low nibble + dv around the rising edge,
  // high nibble + dv^er around the following falling edge.
  task automatic send_byte(input logic [7:0] b, input logic dv, input logic er);
    @(negedge clk); #1;
    rxd = b[3:0];
    ctl = dv;
    @(posedge clk); #1;
    rxd = b[7:4];
    ctl = dv ^ er;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) send_byte(8'h00, 1'b0, 1'b0);
  endtask

  // Preamble (optionally corrupted), SFD, payload i[7:0], then idle.
  task automatic send_frame(input int npay, input int er_at, input bit bad_pre, input int rst_at);
    beats.delete();
    for (int k = 0; k < 7; k++)
      send_byte((bad_pre && k == 2) ? 8'h5A : 8'h55, 1'b1, 1'b0);
    send_byte(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < npay; i++) begin
      if (i == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_out", {20'h0, tvalid, tlast, tuser, tdata}, 32'h0);
        chk("rst_good", {16'h0, good}, 32'h0);
        chk("rst_bad", {16'h0, bad}, 32'h0);
        beats.delete();
      end
      send_byte(8'(i), 1'b1, i == er_at);
      if (i == rst_at) rst_n = 1'b1;
    end
    idle(10);
  endtask

  // Expect n beats i[7:0], tlast only on the final beat carrying exp_user.
  task automatic check_frame(input string tag, input int n, input bit exp_user);
    logic [9:0] exp;
    chk({tag, "_len"}, beats.size(), n);
    for (int i = 0; i < n && i < beats.size(); i++) begin
      exp = {(i == n - 1) ? exp_user : 1'b0, i == n - 1, 8'(i)};
      chk({tag, "_beat"}, {22'h0, beats[i]}, {22'h0, exp});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rxd   = 4'h0;
    ctl   = 1'b0;
    #23;
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tuser", tuser, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_good", good, 0);
    chk("rst_bad", bad, 0);
    rst_n = 1'b1;
    idle(3);

    // In-band status (dv=0, er=1) must be ignored.
    for (int k = 0; k < 3; k++) send_byte(8'h0E, 1'b0, 1'b1);

    send_frame(64, -1, 1'b0, -1);
    check_frame("good64", 64, 1'b0);
    chk("good64_good", good, 1);
    chk("good64_bad", bad, 0);

    send_frame(64, 10, 1'b0, -1);
    check_frame("er64", 64, 1'b1);
    chk("er64_good", good, 1);
    chk("er64_bad", bad, 1);

    send_frame(20, -1, 1'b0, -1);
    check_frame("runt20", 20, 1'b1);
    chk("runt20_bad", bad, 2);

    send_frame(20, -1, 1'b1, -1);
    chk("badpre_len", beats.size(), 0);
    chk("badpre_good", good, 1);
    chk("badpre_bad", bad, 2);

    send_frame(0, -1, 1'b0, -1);
    chk("empty_len", beats.size(), 0);
    chk("empty_bad", bad, 3);

    send_frame(1600, -1, 1'b0, -1);
    check_frame("long", 1518, 1'b1);
    chk("long_last_data", beats.size() == 1518 ? beats[1517][7:0] : 8'h00, 8'hED);
    chk("long_good", good, 1);
    chk("long_bad", bad, 4);

    send_frame(64, -1, 1'b0, 30);
    chk("rst_tail_len", beats.size(), 0);
    chk("rst_tail_good", good, 0);
    chk("rst_tail_bad", bad, 0);

    send_frame(64, -1, 1'b0, -1);
    check_frame("after_rst", 64, 1'b0);
    chk("after_rst_good", good, 1);
    chk("after_rst_good_s", good_s, 1);

    for (int f = 0; f < 3; f++) send_frame(64, -1, 1'b0, -1);
    chk("sat_good", good, 4);
    chk("sat_good_s", good_s, 3);
    chk("sat_bad_s", bad_s, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rgmii_rx_deframer.md
RGMII_RX_DEFRAMER -- requirements
Module: rgmii_rx_deframer

Interface
REQ-001 Parameter MIN_FRAME, default 64, shortest good frame in bytes, counted destination address through FCS.
REQ-002 Parameter MAX_FRAME, default 1518, longest frame in bytes; longer frames are truncated.
REQ-003 Parameter CNT_WIDTH, default 16, width of the statistics counters.
REQ-004 Port clk  in  1  RGMII receive clock; the only clock in the block.
REQ-005 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 Port rgmii_rxd  in  4  DDR data: low nibble on the rising edge, high nibble on the falling edge.
REQ-007 Port rgmii_rx_ctl  in  1  DDR control: RX_DV on the rising edge, RX_DV xor RX_ER on the falling edge.
REQ-008 Port m_axis_tdata  out  8  received frame byte, preamble and SFD stripped.
REQ-009 Port m_axis_tvalid  out  1  tdata valid; there is no tready and no backpressure.
REQ-010 Port m_axis_tlast  out  1  final byte of the frame.
REQ-011 Port m_axis_tuser  out  1  bad-frame flag, qualified by tlast.
REQ-012 Port frames_good  out  CNT_WIDTH  count of good frames, saturating.
REQ-013 Port frames_bad  out  CNT_WIDTH  count of bad frames, saturating.

Function
REQ-014 The iddr sub-module SHALL capture both clock edges and present the rising/falling pair aligned to the rising edge of clk.
REQ-015 Decoded byte = {falling nibble, rising nibble}; dv = ctl_rise; er = ctl_rise xor ctl_fall.
REQ-016 States SHALL be WAIT_IDLE, IDLE, PREAMBLE, PAYLOAD and DROP.
REQ-017 WAIT_IDLE->IDLE when dv=0; IDLE->PREAMBLE when dv=1 and byte=0x55.
REQ-018 IDLE->DROP when dv=1 and byte is not 0x55.
REQ-019 PREAMBLE: byte 0x55 stays; 0xD5 ->PAYLOAD; any other byte, or er=1 ->DROP; dv=0 ->IDLE with no output and no count.
REQ-020 PAYLOAD SHALL hold each byte one cycle, so that tlast is asserted together with the final byte.
REQ-021 A byte that enters the decoder in cycle N SHALL appear on tdata in cycle N+2, where N is the cycle its decoded value first exists.
REQ-022 On dv falling in PAYLOAD, the held byte SHALL be emitted with tlast=1, and the state SHALL go to IDLE.
REQ-023 tuser=1 on tlast if er was seen anywhere in the payload, or if the length is below MIN_FRAME, or if the length exceeds MAX_FRAME.
REQ-024 On the byte that would exceed MAX_FRAME, byte number MAX_FRAME SHALL be emitted with tlast=1 and tuser=1, and the state SHALL go to DROP.
REQ-025 SFD followed immediately by dv=0 (zero payload) SHALL emit nothing and SHALL increment frames_bad.
REQ-026 DROP ->IDLE when dv=0; nothing is emitted while in DROP.
REQ-027 frames_good or frames_bad SHALL increment on the tlast cycle according to tuser, and SHALL saturate at all-ones.
REQ-028 dv=0 with er=1 (in-band status or false carrier) SHALL be ignored in every state.
REQ-029 The byte length counter SHALL be 11+ bits wide and SHALL saturate at MAX_FRAME+1.

Reset
REQ-030 While rst_n=0: tvalid, tlast, tuser and tdata are 0; both counters are 0; the state is WAIT_IDLE; the iddr registers are 0.
REQ-031 Reset release mid-frame SHALL emit nothing until dv has been observed low, then resume normal operation.

Structure
REQ-032 A shared package SHALL hold the state enumeration, the constants PREAMBLE_BYTE=0x55 and SFD_BYTE=0xD5, and the default MIN_FRAME and MAX_FRAME.
REQ-033 There SHALL be one sub-module, iddr: a generic input DDR with a WIDTH parameter of 5 and outputs d1 (rising) and d2 (falling).

Verification
REQ-034 Seven bytes 0x55, then 0xD5, then 64 bytes 0x00..0x3F with dv=1, then dv=0 -> 64 beats 0x00..0x3F; tlast on 0x3F, tuser=0, frames_good=1.
REQ-035 The same frame with er=1 on payload byte 10 -> 64 beats; tlast with tuser=1; frames_bad=1.
REQ-036 A 20-byte payload -> 20 beats; tuser=1 (runt); a preamble byte of 0x5A -> no beats, and no counter change.
REQ-037 A 1600-byte payload -> exactly 1518 beats; tlast and tuser on beat 1518; no further beats until dv=0; frames_bad=1.
REQ-038 rst_n pulsed low during payload byte 30 -> outputs 0 immediately; no beats from the rest of that frame; the next frame is received correctly.
REQ-039 frames_good preset near all-ones by sending 0xFFFF good frames with CNT_WIDTH=16 -> the counter holds 0xFFFF.
